// File: rtl/prng_pkg.sv
// Shared types and the xorshift step used by the jitter PRNG arbiter.
package prng_pkg;

    localparam int RAND_W = 12;
    localparam int PRNG_W = 16;

    typedef logic [RAND_W-1:0] rand_t;

    typedef enum logic {
        WARMUP,
        SERVE
    } prng_arb_state_e;

    // 16-bit xorshift with the (7, 9, 8) triple; never reaches zero from a non-zero seed
    function automatic logic [PRNG_W-1:0] xorshift16(input logic [PRNG_W-1:0] s);
        logic [PRNG_W-1:0] x;
        x = s ^ (s << 7);
        x = x ^ (x >> 9);
        x = x ^ (x << 8);
        return x;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible bit at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = ptr;
        for (int i = 0; i < N; i++) begin
            if (!any && eligible[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/xor_prng.sv
// 16-bit xorshift generator producing a 12-bit value; the state only moves when enabled.
module xor_prng
    import prng_pkg::*;
#(
    parameter logic [PRNG_W-1:0] SEED = 16'h5A3C
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  enable,
    output rand_t rand_num
);

    logic [PRNG_W-1:0] state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (enable) begin
            state <= xorshift16(state);
        end
    end

    // Upper nibble is folded into the top of the output so every state bit contributes
    assign rand_num = state[RAND_W-1:0]
                    ^ {state[PRNG_W-1:RAND_W], {(2*RAND_W-PRNG_W){1'b0}}};

endmodule

// File: rtl/prng_arbiter.sv
// Shares one xor_prng between N_REQ requesters: warm-up draws after reset, then one
// round-robin grant per cycle, advancing the PRNG only when a value is handed out.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int          N_REQ         = 4,
    parameter logic [15:0] SEED          = 16'h5A3C,
    parameter int          WARMUP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [RAND_W-1:0] gnt_data,
    output logic              ready,
    output logic [31:0]       draw_cnt
);

    localparam int PW = $clog2(N_REQ);

    prng_arb_state_e state, state_nxt;
    logic [7:0]       warm_cnt, warm_cnt_nxt;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] winner;
    logic             any_grant;
    logic [PW-1:0]    ptr, ptr_nxt, win_idx;
    logic             prng_en;
    rand_t            rand_num;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WARMUP;
            warm_cnt <= 8'(WARMUP_CYCLES);
        end else begin
            state    <= state_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        warm_cnt_nxt = warm_cnt;
        case (state)
            WARMUP: begin
                if (warm_cnt == 8'd1) begin
                    state_nxt = SERVE;
                end else begin
                    warm_cnt_nxt = warm_cnt - 8'd1;
                end
            end
            SERVE:   state_nxt = SERVE;
            default: state_nxt = WARMUP;
        endcase
    end

    // A requester granted this cycle is masked so a held req cannot win twice in a row
    assign eligible = (state == SERVE) ? (req & ~gnt) : '0;
    assign prng_en  = (state == WARMUP) | any_grant;
    assign ready    = (state == SERVE);

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .any      (any_grant)
    );

    xor_prng #(
        .SEED (SEED)
    ) u_xor_prng (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (prng_en),
        .rand_num (rand_num)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                win_idx = PW'(i);
            end
        end
        ptr_nxt = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            gnt_data <= '0;
            ptr      <= '0;
            draw_cnt <= '0;
        end else begin
            gnt <= winner;
            if (any_grant) begin
                gnt_data <= rand_num;
                ptr      <= ptr_nxt;
                if (draw_cnt != '1) begin
                    draw_cnt <= draw_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Shares one `xor_prng` instance between `N_REQ` ray-generation requesters, which need random jitter values for sub-pixel sampling. After reset it burns a fixed number of warm-up draws. It then issues one 12-bit random value per cycle to at most one requester, chosen round-robin. The PRNG advances only when a value is consumed, so no two grants ever carry the same draw.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `SEED`, 16'h5A3C, forwarded to the internal `xor_prng`
- `WARMUP_CYCLES`, 16, draws discarded after reset (1..255)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `req`  in  N_REQ  level request per requester; held until granted
- `gnt`  out  N_REQ  registered grant, one-hot or zero, one-cycle pulse
- `gnt_data`  out  12  random value belonging to the current `gnt`; valid only while `|gnt`
- `ready`  out  1  high once warm-up is complete
- `draw_cnt`  out  32  total grants issued since reset, saturating at 32'hFFFF_FFFF

## Operation
- FSM states:
  - WARMUP: the reset state. Asserts PRNG `enable` every cycle. An 8-bit counter counts down from `WARMUP_CYCLES`. `req` is ignored and `gnt` = 0.
  - SERVE: entered on the edge where the counter reaches 1, after exactly `WARMUP_CYCLES` enabled edges. The FSM stays in SERVE until reset.
- Arbitration in SERVE, every cycle:
  - Eligible set = `req & ~gnt`. A requester whose `gnt` is high this cycle is masked, so a held `req` does not double-grant.
  - If the eligible set is non-zero, pick the first set bit at or after pointer `ptr`, wrapping from N_REQ-1 to 0.
  - At the next edge: `gnt` ← one-hot of the winner, `gnt_data` ← current PRNG `rand_num`, PRNG `enable` = 1 for that edge, `ptr` ← (winner+1) mod N_REQ, `draw_cnt` increments.
  - If the eligible set is zero, `gnt` ← 0, `gnt_data` holds its previous value, and the PRNG does not advance.
- PRNG contract: `rand_num` changes only on edges where `enable` = 1. Consecutive grants therefore carry consecutive PRNG outputs.
- Requester contract: drop `req` in the cycle its `gnt` is seen. If `req` is still high on the following cycle, it is treated as a new request.
- Reset mid-operation, asynchronous:
  - FSM → WARMUP; `gnt`, `gnt_data`, `draw_cnt`, `ptr` and the PRNG state all go to reset values immediately.
  - Any outstanding request must be re-arbitrated after warm-up.

## Timing
- Output reset values: `gnt` = 0, `gnt_data` = 12'h000, `ready` = 0, `draw_cnt` = 0, `ptr` = 0.
- `ready` rises on the same edge that enters SERVE, i.e. `WARMUP_CYCLES` edges after `rst_n` deasserts.
- Latency: `req` high in cycle t, with `ready` high and no contention → `gnt` high in cycle t+1.
- Throughput: one grant per cycle across all requesters; at most one grant every 2 cycles to the same requester.
- Fairness: a continuously requesting requester is granted within N_REQ cycles.
- A request made during WARMUP is first arbitrated in the cycle `ready` is high and granted the edge after.
- `draw_cnt` at saturation holds its value and grants continue normally.

## Structure
- Package `prng_pkg`:
  - `RAND_W` = 12
  - `typedef logic [RAND_W-1:0] rand_t`
  - FSM enum `prng_arb_state_e` {WARMUP, SERVE}
- Sub-module `rr_arbiter`: parameter N, inputs `eligible` and `ptr`, outputs one-hot `winner` and `any`; purely combinational.
- The pointer register and the FSM live in `prng_arbiter`.
- `xor_prng` is instantiated once, with `enable` = (state == WARMUP) | any_grant.

## Test plan
- Reset/warm-up (`WARMUP_CYCLES`=4):
  - With `req`=4'b1111 from reset, `ready` rises exactly 4 edges after `rst_n`↑ and `gnt` stays 0 until then.
  - The first `gnt` is 4'b0001 on the edge after `ready`↑.
- Round-robin: hold `req`=4'b1111 and drop each `req` on its grant cycle, then re-raise it next cycle. `gnt` sequence is 0001, 0010, 0100, 1000, 0001; `draw_cnt` = 5.
- Uniqueness/ordering: capture `gnt_data` over 1000 grants with random `req` patterns. The values must equal a reference `xor_prng` (SEED 16'h5A3C) model stepped once per grant after 4 warm-up steps. Idle cycles must not advance the sequence.
- Held request: keep `req`=4'b0100 high permanently. `gnt`[2] pulses every other cycle, and `draw_cnt` increments by 1 per pulse only.
- Idle hold: after a grant returning value V, set `req`=0 for 10 cycles. `gnt`=0, `gnt_data`=V, and the next grant returns the PRNG successor of V.
- Reset mid-stream: assert `rst_n`=0 asynchronously between edges while `gnt`=4'b0010.
  - `gnt`, `draw_cnt` and `ready` clear immediately.
  - After release, warm-up repeats and the first granted value equals the first post-reset value from the initial run.
